// File: rtl/wb_copy_master_pkg.sv
// Shared types and constants for the Wishbone block-copy initiator.
package wb_copy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        GAP,
        WRITE,
        FINISH
    } state_t;

    // One bus transfer moves one 32-bit word.
    localparam int WORD_BYTES = 4;

    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int TIMEOUT_CNT_W      = $clog2(DEF_TIMEOUT_CYCLES);

    // Timeout counter width for an arbitrary cycle budget; never narrower than 1.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/wb_copy_master_if.sv
// Wishbone classic bus bundle between the copy initiator and its slave side.
interface wb_copy_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cyc_o;
    logic                  stb_o;
    logic                  we_o;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  ack_i;
    logic [DATA_WIDTH-1:0] data_i;

    modport master (
        output cyc_o, stb_o, we_o, addr_o, data_o,
        input  ack_i, data_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, addr_o, data_o,
        output ack_i, data_i
    );
endinterface

// File: rtl/wb_copy_master.sv
// Autonomous Wishbone classic initiator: copies len words from src to dst,
// one read followed by one write per word, with a one-cycle idle gap after
// every bus cycle. Abort and a per-transfer ack timeout end the copy early.
module wb_copy_master
    import wb_copy_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [LEN_WIDTH-1:0]  words_done_o,
    wb_copy_master_if.master      wb
);

    localparam int WORD_SHIFT = $clog2(WORD_BYTES);
    localparam int WA_W       = ADDR_WIDTH - WORD_SHIFT;
    localparam int TO_W       = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t               state;
    logic                 from_read;   // GAP was entered from READ, so WRITE follows
    logic [WA_W-1:0]      src_w;       // word-granular base addresses
    logic [WA_W-1:0]      dst_w;
    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH-1:0] idx;         // words fully written so far
    logic [TO_W-1:0]      to_cnt;

    logic [LEN_WIDTH-1:0] idx_next;
    logic                 last_word;
    logic                 timed_out;
    logic                 unused_low_bits;

    assign idx_next     = idx + 1'b1;
    assign last_word    = (idx_next == len);
    assign timed_out    = (to_cnt == TO_LAST);
    assign words_done_o = idx;

    // Byte addresses are word-aligned by construction; the low bits never matter.
    assign unused_low_bits = ^{src_addr_i[WORD_SHIFT-1:0], dst_addr_i[WORD_SHIFT-1:0]};

    // Word base plus index, wrapping modulo the address space, low bits forced to 0.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [WA_W-1:0] base,
                                                        input logic [LEN_WIDTH-1:0] i);
        logic [WA_W-1:0] w;
        w = base + WA_W'(i);
        return {w, {WORD_SHIFT{1'b0}}};
    endfunction

    // Copy sequencer; every bus output is registered and set on the edge that enters its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            from_read   <= 1'b0;
            src_w       <= '0;
            dst_w       <= '0;
            len         <= '0;
            idx         <= '0;
            to_cnt      <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            wb.cyc_o    <= 1'b0;
            wb.stb_o    <= 1'b0;
            wb.we_o     <= 1'b0;
            wb.addr_o   <= '0;
            wb.data_o   <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        error_o <= 1'b0;
                        if (len_i != '0) begin
                            src_w     <= src_addr_i[ADDR_WIDTH-1:WORD_SHIFT];
                            dst_w     <= dst_addr_i[ADDR_WIDTH-1:WORD_SHIFT];
                            len       <= len_i;
                            idx       <= '0;
                            to_cnt    <= '0;
                            busy_o    <= 1'b1;
                            wb.cyc_o  <= 1'b1;
                            wb.stb_o  <= 1'b1;
                            wb.we_o   <= 1'b0;
                            wb.addr_o <= word_addr(src_addr_i[ADDR_WIDTH-1:WORD_SHIFT], '0);
                            state     <= READ;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end

                READ: begin
                    if (abort_i || wb.ack_i || timed_out) begin
                        wb.cyc_o <= 1'b0;
                        wb.stb_o <= 1'b0;
                        to_cnt   <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                    if (abort_i) begin
                        busy_o <= 1'b0;
                        state  <= FINISH;
                    end else if (wb.ack_i) begin
                        // data_o doubles as the one-word buffer between read and write.
                        wb.data_o <= wb.data_i;
                        from_read <= 1'b1;
                        state     <= GAP;
                    end else if (timed_out) begin
                        error_o <= 1'b1;
                        busy_o  <= 1'b0;
                        state   <= FINISH;
                    end
                end

                GAP: begin
                    to_cnt <= '0;
                    if (abort_i) begin
                        busy_o <= 1'b0;
                        state  <= FINISH;
                    end else if (from_read) begin
                        wb.cyc_o  <= 1'b1;
                        wb.stb_o  <= 1'b1;
                        wb.we_o   <= 1'b1;
                        wb.addr_o <= word_addr(dst_w, idx);
                        state     <= WRITE;
                    end else begin
                        // Only reached with words remaining: the last write goes straight to FINISH.
                        wb.cyc_o  <= 1'b1;
                        wb.stb_o  <= 1'b1;
                        wb.we_o   <= 1'b0;
                        wb.addr_o <= word_addr(src_w, idx);
                        state     <= READ;
                    end
                end

                WRITE: begin
                    if (abort_i || wb.ack_i || timed_out) begin
                        wb.cyc_o <= 1'b0;
                        wb.stb_o <= 1'b0;
                        to_cnt   <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                    if (wb.ack_i) begin
                        // A write acked in the same cycle as abort still counts.
                        idx <= idx_next;
                        if (last_word || abort_i) begin
                            busy_o <= 1'b0;
                            state  <= FINISH;
                        end else begin
                            from_read <= 1'b0;
                            state     <= GAP;
                        end
                    end else if (abort_i) begin
                        busy_o <= 1'b0;
                        state  <= FINISH;
                    end else if (timed_out) begin
                        error_o <= 1'b1;
                        busy_o  <= 1'b0;
                        state   <= FINISH;
                    end
                end

                FINISH: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_copy_master.sv
// Bench for wb_copy_master: zero-wait slave model with a per-address read stall,
// scoreboard of expected bus transfers, and one task per scenario.
module tb_wb_copy_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] wd;

    logic        stall_en;
    logic [31:0] stall_addr;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    wb_copy_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb();

    wb_copy_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(16), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
        .src_addr_i(src), .dst_addr_i(dst), .len_i(len),
        .busy_o(busy), .done_o(done), .error_o(error), .words_done_o(wd),
        .wb(wb)
    );

    always #5 clk = ~clk;

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] rdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
    endfunction

    // Zero-wait slave; a read of stall_addr is never acknowledged while stall_en is set.
    assign wb.ack_i  = wb.cyc_o && wb.stb_o && !(stall_en && !wb.we_o && wb.addr_o == stall_addr);
    assign wb.data_i = rdata(wb.addr_o);

    // Advance to the next falling edge and score any transfer completing in that cycle.
    task automatic step();
        xfer_t e;
        @(negedge clk);
        if (wb.cyc_o && wb.stb_o && wb.ack_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_extra: got we=%b addr=%h, expected no transfer", wb.we_o, wb.addr_o);
            end else begin
                e = exp_q.pop_front();
                if (wb.we_o !== e.we || wb.addr_o !== e.addr ||
                    (wb.we_o ? wb.data_o : wb.data_i) !== e.data) begin
                    n_bad++;
                    $display("FAIL sb_xfer: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                             wb.we_o, wb.addr_o, wb.we_o ? wb.data_o : wb.data_i, e.we, e.addr, e.data);
                end
            end
        end
    endtask

    // Expected read/write pairs for the first n words of a copy.
    task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] ra;
        logic [31:0] wa;
        for (int i = 0; i < n; i++) begin
            ra = (s & ~32'h3) + 32'(4 * i);
            wa = (d & ~32'h3) + 32'(4 * i);
            exp_q.push_back('{1'b0, ra, rdata(ra)});
            exp_q.push_back('{1'b1, wa, rdata(ra)});
        end
    endtask

    // Pulse start for one cycle; returns at the falling edge of the first cycle after it.
    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        src = s; dst = d; len = n; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Cycle index (1 = first cycle after start) at which done is seen, plus cycles with cyc high.
    task automatic wait_done(input int max, output bit got, output int at, output int cyc_n);
        got = 1'b0; at = 0; cyc_n = 0;
        for (int k = 1; k <= max; k++) begin
            if (wb.cyc_o) cyc_n++;
            if (done) begin
                got = 1'b1; at = k;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; src = '0; dst = '0; len = '0;
        stall_en = 1'b0; stall_addr = '0;
        repeat (3) step();
        n_cmp++; if ({wb.cyc_o, wb.stb_o, wb.we_o, busy, done, error} !== 6'b0) begin n_bad++;
            $display("FAIL reset_ctrl: got %b expected 000000", {wb.cyc_o, wb.stb_o, wb.we_o, busy, done, error}); end
        n_cmp++; if (wb.addr_o !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", wb.addr_o); end
        n_cmp++; if (wb.data_o !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", wb.data_o); end
        n_cmp++; if (wd !== 16'h0) begin n_bad++; $display("FAIL reset_words: got %0d expected 0", wd); end
        rst = 1'b0;
        repeat (2) step();
        n_cmp++; if ({wb.cyc_o, busy, done} !== 3'b0) begin n_bad++;
            $display("FAIL reset_idle: got %b expected 000", {wb.cyc_o, busy, done}); end
    endtask

    task automatic test_basic_copy();
        bit got; int at; int cn;
        push_copy(32'h100, 32'h8000_0000, 3);
        do_start(32'h100, 32'h8000_0000, 16'd3);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b expected 1", busy); end
        wait_done(200, got, at, cn);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b expected 1", got); end
        n_cmp++; if (at !== 13) begin n_bad++; $display("FAIL basic_latency: got %0d expected 13", at); end
        n_cmp++; if (cn !== 6) begin n_bad++; $display("FAIL basic_cyc_cycles: got %0d expected 6", cn); end
        n_cmp++; if (wd !== 16'd3) begin n_bad++; $display("FAIL basic_words: got %0d expected 3", wd); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL basic_error: got %b expected 0", error); end
        n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL basic_missing: got %0d left expected 0", exp_q.size()); end
        step();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width: got %b expected 0", done); end
    endtask

    task automatic test_zero_len();
        bit got; int at; int cn;
        do_start(32'h40, 32'h80, 16'd0);
        wait_done(50, got, at, cn);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b expected 1", got); end
        n_cmp++; if (at !== 2) begin n_bad++; $display("FAIL zero_latency: got %0d expected 2", at); end
        n_cmp++; if (cn !== 0) begin n_bad++; $display("FAIL zero_cyc: got %0d expected 0", cn); end
        n_cmp++; if (wd !== 16'd3) begin n_bad++; $display("FAIL zero_words: got %0d expected 3", wd); end
        step();
    endtask

    task automatic test_timeout();
        bit got; int at; int cn;
        stall_en = 1'b1; stall_addr = 32'h204;
        push_copy(32'h200, 32'h8000_0200, 1);
        do_start(32'h200, 32'h8000_0200, 16'd2);
        wait_done(200, got, at, cn);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL to_done: got %b expected 1", got); end
        n_cmp++; if (at !== 22) begin n_bad++; $display("FAIL to_latency: got %0d expected 22", at); end
        n_cmp++; if (cn !== 2 + TO) begin n_bad++; $display("FAIL to_cyc_cycles: got %0d expected %0d", cn, 2 + TO); end
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL to_error: got %b expected 1", error); end
        n_cmp++; if (wd !== 16'd1) begin n_bad++; $display("FAIL to_words: got %0d expected 1", wd); end
        n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL to_missing: got %0d left expected 0", exp_q.size()); end
        step();
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b expected 1", error); end
        stall_en = 1'b0;
        push_copy(32'h400, 32'h500, 1);
        do_start(32'h400, 32'h500, 16'd1);
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL to_clear: got %b expected 0", error); end
        wait_done(200, got, at, cn);
        n_cmp++; if (got !== 1'b1 || wd !== 16'd1) begin n_bad++;
            $display("FAIL to_recover: got done=%b words=%0d expected done=1 words=1", got, wd); end
        step();
    endtask

    task automatic test_abort();
        bit got; int at; int cn;
        push_copy(32'h600, 32'h8000_0600, 3);
        do_start(32'h600, 32'h8000_0600, 16'd5);
        repeat (10) step();
        n_cmp++; if ({wb.cyc_o, wb.we_o, wb.ack_i} !== 3'b111) begin n_bad++;
            $display("FAIL abort_in_write3: got %b expected 111", {wb.cyc_o, wb.we_o, wb.ack_i}); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_done(50, got, at, cn);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL abort_done: got %b expected 1", got); end
        n_cmp++; if (at !== 2) begin n_bad++; $display("FAIL abort_latency: got %0d expected 2", at); end
        n_cmp++; if (wd !== 16'd3) begin n_bad++; $display("FAIL abort_words: got %0d expected 3", wd); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL abort_error: got %b expected 0", error); end
        n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL abort_missing: got %0d left expected 0", exp_q.size()); end
        step();
    endtask

    task automatic test_addr_wrap();
        bit got; int at; int cn;
        push_copy(32'hFFFF_FFFF, 32'h8000_0103, 2);
        do_start(32'hFFFF_FFFF, 32'h8000_0103, 16'd2);
        wait_done(100, got, at, cn);
        n_cmp++; if (got !== 1'b1 || at !== 9) begin n_bad++;
            $display("FAIL wrap_done: got done=%b at=%0d expected done=1 at=9", got, at); end
        n_cmp++; if (wd !== 16'd2) begin n_bad++; $display("FAIL wrap_words: got %0d expected 2", wd); end
        n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL wrap_missing: got %0d left expected 0", exp_q.size()); end
        step();
    endtask

    task automatic test_reset_mid();
        bit got; int at; int cn; bit seen;
        stall_en = 1'b1; stall_addr = 32'h300;
        do_start(32'h300, 32'h700, 16'd2);
        repeat (2) step();
        n_cmp++; if (wb.cyc_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_read: got %b expected 1", wb.cyc_o); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({wb.cyc_o, wb.stb_o, busy} !== 3'b000) begin n_bad++;
            $display("FAIL rstmid_async: got %b expected 000", {wb.cyc_o, wb.stb_o, busy}); end
        seen = 1'b0;
        repeat (3) begin step(); seen |= done; end
        rst = 1'b0;
        repeat (4) begin step(); seen |= done; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_done: got %b expected 0", seen); end
        stall_en = 1'b0;
        push_copy(32'h300, 32'h700, 2);
        do_start(32'h300, 32'h700, 16'd2);
        wait_done(100, got, at, cn);
        n_cmp++; if (got !== 1'b1 || wd !== 16'd2 || error !== 1'b0) begin n_bad++;
            $display("FAIL rstmid_restart: got done=%b words=%0d err=%b expected 1/2/0", got, wd, error); end
        n_cmp++; if (exp_q.size() !== 0) begin n_bad++; $display("FAIL rstmid_missing: got %0d left expected 0", exp_q.size()); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_zero_len();
        test_timeout();
        test_abort();
        test_addr_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_copy_master.md
Name: wb_copy_master

Overview:
- Autonomous Wishbone classic initiator: copies a block of 32-bit words from a source address range to a destination address range, one word at a time (read, then write).
- Lets software or a test harness move data between main memory (bit 31 = 0) and peripherals (bit 31 = 1) without the CPU.
- Sits as a second bus master beside the processor, behind a master arbiter that is outside this block's scope.
- Configured through simple level/pulse ports driven by a register shell or testbench.

Parameters:
- ADDR_WIDTH, 32: Wishbone address width; byte addresses.
- DATA_WIDTH, 32: Wishbone data width; one transfer moves one word.
- LEN_WIDTH, 16: width of the word-count register.
- TIMEOUT_CYCLES, 1024: cycles without ack_i before a transfer is aborted with error.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  pulse; launches a copy when idle.
- abort_i  in  1  pulse; terminates the copy in progress.
- src_addr_i  in  ADDR_WIDTH  source byte address, sampled on start.
- dst_addr_i  in  ADDR_WIDTH  destination byte address, sampled on start.
- len_i  in  LEN_WIDTH  number of words, sampled on start.
- busy_o  out  1  high from the cycle after an accepted start until completion.
- done_o  out  1  one-cycle pulse at completion (normal, abort or error).
- error_o  out  1  sticky timeout flag; cleared by the next accepted start.
- words_done_o  out  LEN_WIDTH  count of words fully written.
- cyc_o, stb_o, we_o  out  1  Wishbone classic master controls.
- addr_o  out  ADDR_WIDTH  Wishbone address.
- data_o  out  DATA_WIDTH  Wishbone write data.
- ack_i  in  1  Wishbone acknowledge.
- data_i  in  DATA_WIDTH  Wishbone read data.

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters and buffer 0. Assertion of rst mid-transfer drops cyc_o/stb_o immediately (asynchronously); no done_o pulse is produced.
- States: IDLE, READ, GAP, WRITE, FINISH.
- IDLE:
  - start_i with len_i != 0: latch src, dst and len; clear idx, words_done_o and error_o; go to READ next cycle.
  - start_i with len_i == 0: clear error_o; go to FINISH; no bus activity.
  - start_i while not IDLE is ignored.
- READ: cyc_o = stb_o = 1, we_o = 0, addr_o = {src[AW-1:2] + idx, 2'b00}. Low two address bits are always driven 0; the address wraps modulo 2^ADDR_WIDTH. On ack_i: latch data_i into the buffer, go to GAP.
- GAP: cyc_o = stb_o = 0 for exactly one cycle, then:
  - go to WRITE if arriving from READ;
  - go to READ if arriving from WRITE and idx < len.
- WRITE: cyc_o = stb_o = we_o = 1, addr_o = dst-based word address (same wrap rule), data_o = buffer. On ack_i: idx and words_done_o increment. If the new idx == len, go to FINISH; otherwise go to GAP.
- Bus signal timing: all bus outputs are registered. cyc_o/stb_o rise the cycle after entry and fall on the cycle after ack_i is sampled. addr_o, we_o and data_o are stable while stb_o is high.
- Throughput: 2 bus cycles plus 2 gap cycles per word with a zero-wait slave (ack_i high on the first cycle of stb_o).
- FINISH: pulse done_o for one cycle, busy_o = 0, return to IDLE.
- Timeout: a counter runs in READ and WRITE and clears on every state entry. When it reaches TIMEOUT_CYCLES - 1 without ack_i: drop cyc/stb, set error_o, go to FINISH. words_done_o holds the completed count.
- abort_i in READ/WRITE/GAP: drop cyc/stb next cycle, go to FINISH; error_o is not set. If abort_i and ack_i coincide in WRITE, the write is counted before aborting. abort_i in IDLE/FINISH has no effect.
- ack_i outside READ/WRITE is ignored.
- LEN_WIDTH all-ones length is legal; idx does not overflow before termination.

Decomposition:
- Package wb_copy_pkg holds:
  - state_t enum (IDLE, READ, GAP, WRITE, FINISH);
  - WORD_BYTES = 4;
  - localparam for the timeout counter width = $clog2(TIMEOUT_CYCLES).
- Single module; no sub-module is warranted. The timeout counter stays inline.

Test Plan:
- src = 0x100, dst = 0x8000_0000, len = 3, zero-wait slave with memory[0x100..0x108] = {A, B, C} -> writes A, B, C to 0x8000_0000/04/08 in order; done_o pulses once; words_done_o = 3; error_o = 0.
- len = 0 start -> done_o pulses 2 cycles after start; cyc_o never asserted.
- Slave withholds ack on the 2nd read, TIMEOUT_CYCLES = 16 -> cyc_o drops after 16 cycles; error_o = 1; words_done_o = 1; the next start clears error_o.
- abort_i during the 3rd WRITE of len = 5, coincident with ack_i -> words_done_o = 3, done_o pulse, error_o = 0.
- src = 0xFFFF_FFFC, len = 2 -> read addresses 0xFFFF_FFFC then 0x0000_0000; src low bits 2'b11 -> addr_o[1:0] = 0.
- rst asserted mid-READ -> cyc_o/stb_o/busy_o go 0 before the next clock edge; no done_o; a fresh start after reset completes normally.
